// File: rtl/mprj_io_arbiter.sv
// Round-robin arbiter sharing the mprj pad bus between NUM_REQ requesters,
// with a bounded hold time and one all-enables-off turnaround cycle between owners.
module mprj_io_arbiter #(
  parameter int unsigned GPIO_SIZE = 38,
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned MAX_HOLD  = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*GPIO_SIZE-1:0]   req_data,
  input  logic [NUM_REQ*GPIO_SIZE-1:0]   req_oe,
  input  logic                           force_off,
  output logic [NUM_REQ-1:0]             grant,
  output logic [2:0]                     owner_id,
  output logic                           busy,
  output logic [GPIO_SIZE-1:0]           mprj_o,
  output logic [GPIO_SIZE-1:0]           mprj_en
);

  localparam int unsigned HW = $clog2(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

  state_t               state_q, state_d;
  logic [2:0]           owner_q, owner_d;
  logic [2:0]           rr_ptr_q, rr_ptr_d;
  logic [HW-1:0]        hold_q, hold_d;
  logic [GPIO_SIZE-1:0] mprj_o_q, mprj_o_d;
  logic [GPIO_SIZE-1:0] mprj_en_q, mprj_en_d;

  logic [2*NUM_REQ-1:0] req_rot;
  logic [3:0]           scan_sum;
  logic [2:0]           pick;
  logic                 found;
  logic [NUM_REQ-1:0]   owner_oh;
  logic [GPIO_SIZE-1:0] sel_data, sel_oe;
  logic                 release_bus;

  // Rotating a doubled request vector puts rr_ptr at bit 0, so the first set bit wins.
  always_comb begin
    req_rot  = {req, req} >> rr_ptr_q;
    scan_sum = '0;
    pick     = '0;
    found    = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found && req_rot[i]) begin
        found    = 1'b1;
        scan_sum = {1'b0, rr_ptr_q} + 4'(i);
        if (scan_sum >= 4'(NUM_REQ)) scan_sum = scan_sum - 4'(NUM_REQ);
        pick     = scan_sum[2:0];
      end
    end
  end

  always_comb begin
    owner_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner_q;
    sel_data = '0;
    sel_oe   = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (owner_oh[j]) begin
        sel_data = req_data[j*GPIO_SIZE +: GPIO_SIZE];
        sel_oe   = req_oe[j*GPIO_SIZE +: GPIO_SIZE];
      end
    end
    release_bus = !(|(req & owner_oh)) || ((hold_q == HOLD_LAST) && (|(req & ~owner_oh)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      rr_ptr_q  <= '0;
      hold_q    <= '0;
      mprj_o_q  <= '0;
      mprj_en_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_ptr_q  <= rr_ptr_d;
      hold_q    <= hold_d;
      mprj_o_q  <= mprj_o_d;
      mprj_en_q <= mprj_en_d;
    end
  end

  // Enables are loaded only when the owner keeps the bus, so TURN always shows mprj_en=0.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_ptr_d  = rr_ptr_q;
    hold_d    = hold_q;
    mprj_o_d  = mprj_o_q;
    mprj_en_d = '0;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          owner_d = pick;
          hold_d  = '0;
        end
      end
      GRANT: begin
        mprj_o_d = sel_data;
        if (hold_q != HOLD_LAST) hold_d = hold_q + 1'b1;
        if (release_bus) state_d = TURN;
        else if (!force_off) mprj_en_d = sel_oe;
      end
      TURN: begin
        state_d  = IDLE;
        rr_ptr_d = (owner_q == 3'(NUM_REQ - 1)) ? '0 : owner_q + 3'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    grant    = (state_q == GRANT) ? owner_oh : '0;
    busy     = (state_q == GRANT);
    owner_id = owner_q;
    mprj_o   = mprj_o_q;
    mprj_en  = mprj_en_q;
  end

endmodule

// File: tb/tb_mprj_io_arbiter.sv
// Self-checking bench for mprj_io_arbiter: directed scenarios plus randomized
// traffic, all compared every cycle against a behavioural bus-ownership model.
module tb_mprj_io_arbiter;

  localparam int G = 38;
  localparam int N = 4;
  localparam int H = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req;
  logic [N*G-1:0]   req_data;
  logic [N*G-1:0]   req_oe;
  logic             force_off;
  logic [N-1:0]     grant;
  logic [2:0]       owner_id;
  logic             busy;
  logic [G-1:0]     mprj_o;
  logic [G-1:0]     mprj_en;

  int n_checks = 0;
  int n_fail   = 0;

  mprj_io_arbiter #(.GPIO_SIZE(G), .NUM_REQ(N), .MAX_HOLD(H)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_oe(req_oe),
    .force_off(force_off), .grant(grant), .owner_id(owner_id), .busy(busy),
    .mprj_o(mprj_o), .mprj_en(mprj_en)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural model: who owns the bus, for how long, and whether we are in the gap.
  bit           m_owned;      // someone holds the bus
  int           m_gap;        // 1 while in the single turnaround cycle
  int           m_owner;
  int           m_ptr;
  int           m_cycles;     // cycles owned so far by current owner
  logic [G-1:0] m_o;
  logic [G-1:0] m_en;

  task automatic model_reset();
    m_owned = 0; m_gap = 0; m_owner = 0; m_ptr = 0; m_cycles = 0;
    m_o = '0; m_en = '0;
  endtask

  task automatic model_step();
    int  cand;
    bit  others;
    bit  leave;
    if (m_gap == 1) begin
      m_en  = '0;
      m_ptr = (m_owner + 1) % N;
      m_gap = 0;
    end else if (!m_owned) begin
      m_en = '0;
      cand = -1;
      for (int k = 0; k < N; k++)
        if (cand < 0 && req[(m_ptr + k) % N]) cand = (m_ptr + k) % N;
      if (cand >= 0) begin
        m_owner = cand; m_owned = 1; m_cycles = 0;
      end
    end else begin
      others = 0;
      for (int k = 0; k < N; k++) if (k != m_owner && req[k]) others = 1;
      m_cycles++;
      leave = !req[m_owner] || (m_cycles >= H && others);
      m_o   = req_data[m_owner*G +: G];
      m_en  = (leave || force_off) ? '0 : req_oe[m_owner*G +: G];
      if (leave) begin
        m_owned = 0; m_gap = 1;
      end
    end
  endtask

  task automatic compare_all();
    logic [N-1:0] eg;
    eg = m_owned ? (N'(1) << m_owner) : '0;
    check("grant",    grant,    eg);
    check("busy",     busy,     m_owned);
    check("owner_id", owner_id, m_owner);
    check("mprj_o",   mprj_o,   m_o);
    check("mprj_en",  mprj_en,  m_en);
    check("onehot",   $countones(grant) <= 1, 1);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  // Asynchronous reset pulse mid-cycle; outputs must clear before any clock edge.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    check("rst_grant", grant, 0);
    check("rst_busy",  busy, 0);
    check("rst_o",     mprj_o, 0);
    check("rst_en",    mprj_en, 0);
    model_reset();
    compare_all();
    #2 rst = 1'b0;
  endtask

  function automatic logic [G-1:0] rand38();
    logic [63:0] v;
    v = {$urandom, $urandom};
    return v[G-1:0];
  endfunction

  int exp_order [5] = '{0, 1, 2, 3, 0};

  initial begin
    int seen, gap, own, k, cnt;
    logic [G-1:0] v, oe1;

    rst = 1'b1; req = '0; req_data = '0; req_oe = '0; force_off = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    rst = 1'b0;

    // Single requester
    req = 4'b0010; req_data[1*G +: G] = 38'h2A5; req_oe[1*G +: G] = '1;
    cycle();
    check("sr_grant", grant, 4'b0010);
    check("sr_en0",   mprj_en, 0);
    cycle();
    check("sr_o",  mprj_o, 38'h2A5);
    check("sr_en", mprj_en, {G{1'b1}});
    cycle();
    req = '0;
    cycle();
    check("sr_turn_en", mprj_en, 0);
    check("sr_turn_busy", busy, 0);
    cycle();
    check("sr_idle_busy", busy, 0);

    // Reset while owner 2 drives
    req = 4'b0100; req_data[2*G +: G] = 38'h1234; req_oe[2*G +: G] = '1;
    cycle(); cycle();
    check("mid_owner", owner_id, 2);
    check("mid_o", mprj_o, 38'h1234);
    do_reset();

    // Round-robin order, each owner releasing after 3 cycles
    for (int i = 0; i < N; i++) begin
      req_data[i*G +: G] = rand38(); req_oe[i*G +: G] = rand38();
    end
    req = '1; seen = 0; gap = 0; own = 0;
    for (int c = 0; c < 100 && seen < 5; c++) begin
      cycle();
      if (busy && own == 0) begin
        check("rr_order", owner_id, exp_order[seen]);
        if (seen > 0) check("rr_gap", gap, 2);
        seen++;
      end
      if (busy) begin own++; gap = 0; end
      else begin own = 0; gap++; end
      req = '1;
      if (busy && own == 3) req[owner_id] = 1'b0;
    end
    check("rr_done", seen, 5);

    // Hold timeout with a waiting competitor
    do_reset();
    req = 4'b1001;
    cycle();
    cnt = 0;
    for (k = 0; k < 40 && grant == 4'b0001; k++) begin
      cnt++;
      cycle();
    end
    check("hold_len", cnt, H);
    check("hold_turn", busy, 0);
    cycle();
    check("hold_idle", busy, 0);
    cycle();
    check("hold_next", grant, 4'b1000);

    // Lone requester is never preempted
    do_reset();
    req = 4'b0001;
    cycle();
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      cycle();
      if (!busy) cnt++;
    end
    check("alone_hold", cnt, 0);

    // force_off during owner 1's grant
    do_reset();
    oe1 = rand38() | 38'h1;
    req = 4'b0010; req_oe[1*G +: G] = oe1;
    cycle(); cycle();
    check("fo_en_before", mprj_en, oe1);
    force_off = 1'b1;
    cycle();
    check("fo_en_off", mprj_en, 0);
    v = rand38(); req_data[1*G +: G] = v;
    cycle();
    check("fo_track", mprj_o, v);
    check("fo_en_still", mprj_en, 0);
    force_off = 1'b0;
    cycle();
    check("fo_restore", mprj_en, oe1);

    // Owner 0 releases as requester 2 arrives
    do_reset();
    req = 4'b0001;
    cycle(); cycle(); cycle();
    req = 4'b0100;
    cycle();
    check("sim_turn", grant, 0);
    cycle();
    check("sim_idle", grant, 0);
    cycle();
    check("sim_grant", grant, 4'b0100);

    // Randomized traffic
    do_reset();
    req = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < N; b++) if ($urandom_range(7) == 0) req[b] = ~req[b];
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(3) == 0) req_data[b*G +: G] = rand38();
        if ($urandom_range(15) == 0)
          req_oe[b*G +: G] = ($urandom_range(1) == 0) ? '1 : rand38();
      end
      force_off = ($urandom_range(9) == 0);
      if ($urandom_range(499) == 0) do_reset();
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mprj_io_arbiter.md
Name: mprj_io_arbiter

Overview:
- Shares the 38-bit mprj output pad bus between NUM_REQ requesters. Typical requesters are the firmware GPIO path, the user-project loopback and the test pattern generator.
- Round-robin arbitration with a bounded hold time.
- Inserts one bus-turnaround cycle with all output enables dropped between owners.
- Sits between the requesters and the mprj pad drivers (mprj_o / mprj_en).

Parameters:
- GPIO_SIZE, 38, pad bus width.
- NUM_REQ, 4, number of requesters (2..8).
- MAX_HOLD, 16, maximum consecutive owned cycles while another requester is waiting (>=2).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  per-requester bus request, level-sensitive.
- req_data  in  NUM_REQ*GPIO_SIZE  packed output values; requester i occupies bits [i*GPIO_SIZE +: GPIO_SIZE].
- req_oe  in  NUM_REQ*GPIO_SIZE  packed per-pin output enables, same packing, 1 = drive.
- force_off  in  1  global pad disable, e.g. from the mprj top pin.
- grant  out  NUM_REQ  one-hot grant, registered.
- owner_id  out  3  index of the current owner; valid while busy=1.
- busy  out  1  high in GRANT state.
- mprj_o  out  GPIO_SIZE  registered pad output value.
- mprj_en  out  GPIO_SIZE  registered pad output enable.

Behaviour:
- Reset (async, any time, including mid-grant):
  - state=IDLE, grant=0, owner_id=0, busy=0.
  - mprj_o=0, mprj_en=0, rr_ptr=0, hold_cnt=0.
- States:
  - IDLE: grant=0. If any req bit is set: choose the first set bit scanning upward from rr_ptr, wrapping modulo NUM_REQ. Set grant one-hot, set owner_id, clear hold_cnt, go to GRANT. Otherwise stay in IDLE.
  - GRANT: every cycle, register mprj_o<=req_data[owner] and mprj_en<=req_oe[owner] (forced to 0 if force_off). hold_cnt increments and saturates at MAX_HOLD-1. Exit to TURN if either:
    - req[owner]=0, or
    - hold_cnt==MAX_HOLD-1 and some other req bit is set.
    If hold_cnt saturates with no other requester waiting, stay in GRANT (no preemption).
  - TURN, exactly 1 cycle: grant=0, busy=0, mprj_en<=0, mprj_o holds its last value. Set rr_ptr<=(owner+1) mod NUM_REQ, then go to IDLE.
- Latency:
  - req sampled high at edge k in IDLE -> grant high after edge k.
  - First owner data on mprj_o/mprj_en after edge k+1.
  - Minimum owner-to-owner gap: TURN + IDLE = 2 cycles with no owner.
- mprj_en is 0 in IDLE and TURN. mprj_o is 0 after reset and otherwise holds its last driven value.
- force_off: while high, mprj_en<=0 in all states. Arbitration, grant and mprj_o are unaffected.
- Requester dropping req while not granted: no effect.
- Owner changing req_data mid-grant: the change appears on mprj_o one cycle later.
- Simultaneous release by the owner and a new request from another requester: go to TURN as normal; the new request is arbitrated in IDLE.
- Round-robin fairness: any continuously requesting requester is granted within (NUM_REQ-1)*(MAX_HOLD+2) cycles.
- grant is always one-hot or zero, never multi-hot.

Test Plan:
- Reset mid-GRANT: assert rst while owner 2 is driving 38'h1234 -> grant=0, mprj_o=0, mprj_en=0 immediately, without a clock edge. After release, rr_ptr restarts at 0.
- Single requester: req=4'b0010, req_oe[1]=all ones, req_data[1]=38'h2A5 -> grant=4'b0010 one cycle later, mprj_o=38'h2A5 and mprj_en=all ones the cycle after. Dropping req gives one TURN cycle with mprj_en=0, then IDLE.
- Round-robin order: req=4'b1111 held with each owner releasing after 3 cycles -> grant order 0,1,2,3,0. Exactly 2 no-owner cycles between owners.
- Hold timeout: req0 and req3 held continuously, MAX_HOLD=16 -> owner 0 keeps the bus for exactly 16 cycles, then TURN, then owner 3. Alone, req0 keeps the bus indefinitely.
- force_off: raise force_off during owner 1's grant -> mprj_en=0 the next cycle while mprj_o keeps tracking req_data[1]. Lowering it restores req_oe[1] one cycle later.
- Simultaneous events: owner 0 drops req in the same cycle req2 rises with rr_ptr=0 -> TURN, then IDLE, then grant=4'b0100. Check no cycle with two grant bits set.
